oven_time_entry: RTL and testbench
==================================

Name: oven_time_entry

Overview:
- Input-side counterpart of the oven display path: turns raw board keys and switches into a cook time and runs the countdown.
- Holds the time as four BCD digits (mm:ss) and steps through entry, run, pause and done states.
- Drives the BCD digits, the remaining time in binary seconds (13 bits, the display's time format), and running/done status.

Parameters:
- CLK_HZ, 50000000, clk cycles per 1 s countdown tick.
- DEBOUNCE_CYCLES, 500000, consecutive stable synchronized samples required to accept a key level change.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- key0  input  1  raw pushbutton, active-low: enter digit.
- key1  input  1  raw pushbutton, active-low: start/pause/acknowledge.
- digit_sw  input  4  BCD digit to enter (board switches sw3..sw0).
- door_open  input  1  level, door interlock (sw4).
- clear  input  1  level, clear/cancel (sw5).
- time_bcd  output  16  {min_tens, min_ones, sec_tens, sec_ones}.
- remaining  output  13  time_bcd as binary seconds = (10*mt+mo)*60 + 10*st+so; max 6039.
- running  output  1  high in RUN.
- done  output  1  high in DONE.

Behaviour:
- Reset (rst=1 at posedge): state IDLE, time_bcd=0, remaining=0, running=0, done=0, prescaler=0, both debounced keys = released, synchronizers = 1.
- Key path (per key): 2-FF synchronizer, then debounce counter. The debounced level changes only after DEBOUNCE_CYCLES consecutive samples that differ from it. The press event is a 1-cycle pulse when the debounced level goes 1->0. Total press latency = 2 + DEBOUNCE_CYCLES cycles (+1 registered pulse).
- Event priority each cycle: rst > clear > door_open > key1 press > tick > key0 press. When key1 and key0 events coincide, key0 is discarded.
- States: IDLE, RUN, PAUSE, DONE.
- IDLE:
  - key0 press with digit_sw<=9: shift left, time_bcd <= {d2,d1,d0,digit_sw}, dropping the oldest digit.
  - digit_sw>9: press ignored.
  - key1 press with nonzero time and door closed: RUN, prescaler cleared.
  - key1 press with zero time or door open: no action.
- RUN:
  - Prescaler counts 0..CLK_HZ-1; tick = 1-cycle pulse at CLK_HZ-1. The first decrement lands exactly CLK_HZ cycles after entering RUN.
  - On tick, BCD decrement with borrow: so>0 -> so-1. Else so=9 and: st>0 -> st-1; else st=5 and minutes borrow the same way (mo then mt).
  - Seconds fields above 59 (e.g. 0:90) count down naturally: 0:90 -> 0:89.
  - Tick decrementing 00:01 -> 00:00: next state DONE.
  - key1 press -> PAUSE; a coincident tick is dropped.
  - door_open=1 -> PAUSE.
  - Prescaler frozen (holds value) outside RUN.
- PAUSE:
  - Time held.
  - key1 press with door closed -> RUN; prescaler resumes from its held value.
  - key0 ignored.
- DONE:
  - time_bcd=0, done=1.
  - key1 press -> IDLE.
  - key0 press -> IDLE with time_bcd = {0,0,0,digit_sw} if digit_sw<=9, else IDLE with 0.
- clear=1 (any state): next cycle IDLE, time_bcd=0; prescaler not cleared. While held, all key events are ignored.
- Outputs:
  - running, done and time_bcd are registered, updated on the same edge as the state change.
  - remaining is combinational from time_bcd (no extra latency). It is width-safe: 99*60+99=6039 < 8192.
- rst mid-RUN: all registers return to reset values on that edge; no tick is produced.

Test Plan:
(All with CLK_HZ=10, DEBOUNCE_CYCLES=4.)
- Entry: digit_sw=1,2,3 each followed by key0 press (held 8 cycles) -> time_bcd=0x0123, remaining=83. Then digit_sw=12 + key0 press -> unchanged 0x0123.
- Countdown/borrow: load 01:00, key1 press -> running=1. After 10 cycles -> 00:59 (remaining 59). Bounce key0 with 2-cycle glitches throughout -> no digit entry.
- Completion: load 00:02, start -> 00:01 at +10, 00:00 and done=1, running=0 at +20. key1 press -> IDLE, done=0.
- Pause/door: 00:90 running. Assert door_open at cycle 5 of a tick period -> PAUSE next edge, time 00:90 held 50 cycles. Deassert, key1 press -> decrements to 00:89 exactly 5 cycles after RUN re-entry.
- Priorities: key1 press on the tick cycle in RUN -> PAUSE with no decrement. clear pulse during RUN at 00:40 -> IDLE, time 0. key1 press with time 0 -> stays IDLE.
- Reset: rst during RUN at 00:05 -> all outputs 0, IDLE. Press from reset state without prior release still requires a full debounce window.

Source files
------------

// File: rtl/oven_time_entry.sv
// oven_time_entry
// Turns the raw board keys and switches of the oven front panel into a
// four-digit BCD cook time (mm:ss) and runs the one-second countdown.
//
// Ports
//   clk        system clock
//   rst        synchronous reset, active-high
//   key0       raw pushbutton, active-low: enter the digit on digit_sw
//   key1       raw pushbutton, active-low: start / pause / acknowledge
//   digit_sw   BCD digit to enter (values above 9 are ignored)
//   door_open  door interlock level
//   clear      clear / cancel level
//   time_bcd   {min_tens, min_ones, sec_tens, sec_ones}
//   remaining  time_bcd expressed as binary seconds (max 6039)
//   running    high while counting down
//   done       high once the countdown has reached 00:00
module oven_time_entry #(
   parameter int CLK_HZ          = 50000000,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        key0,
   input  logic        key1,
   input  logic [3:0]  digit_sw,
   input  logic        door_open,
   input  logic        clear,
   output logic [15:0] time_bcd,
   output logic [12:0] remaining,
   output logic        running,
   output logic        done
);

   localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
   localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_PAUSE,
      ST_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [15:0]         time_q, time_d;
   logic [PW-1:0]       presc_q, presc_d;
   logic                running_q, done_q;

   // Key path registers, bit 0 = key0, bit 1 = key1
   logic [1:0]          sync1_q, sync2_q;
   logic [1:0]          level_q, level_d;
   logic [1:0]          press_q, press_d;
   logic [1:0][DW-1:0]  dbCnt_q, dbCnt_d;

   logic                tick;
   logic                digitOk;
   logic [15:0]         decTime;

   // BCD countdown step with borrow. Seconds fields above 59 simply count
   // down as decimal numbers; only a seconds borrow reloads the field to 59.
   function automatic logic [15:0] bcdDecrement(input logic [15:0] t);
      logic [3:0] mt, mo, st, so;
      {mt, mo, st, so} = t;
      if (so != 4'd0) begin
         so = so - 4'd1;
      end else begin
         so = 4'd9;
         if (st != 4'd0) begin
            st = st - 4'd1;
         end else begin
            st = 4'd5;
            if (mo != 4'd0) begin
               mo = mo - 4'd1;
            end else begin
               mo = 4'd9;
               mt = mt - 4'd1;
            end
         end
      end
      return {mt, mo, st, so};
   endfunction

   // Debounce: the accepted level only follows the synchronized key once it
   // has disagreed for DEBOUNCE_CYCLES samples in a row; any agreeing sample
   // restarts the count. A 1->0 change of the accepted level is a press.
   always_comb begin
      level_d = level_q;
      press_d = 2'b00;
      dbCnt_d = '0;
      for (int k = 0; k < 2; k++) begin
         if (sync2_q[k] != level_q[k]) begin
            if (dbCnt_q[k] == DB_LAST) begin
               level_d[k] = sync2_q[k];
               press_d[k] = ~sync2_q[k];
            end else begin
               dbCnt_d[k] = dbCnt_q[k] + DW'(1);
            end
         end
      end
   end

   // Key synchronizers and debounce state; synchronizers and levels reset to
   // the released level so a key held through reset still needs a full window.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 2'b11;
         sync2_q <= 2'b11;
         level_q <= 2'b11;
         press_q <= 2'b00;
         dbCnt_q <= '0;
      end else begin
         sync1_q <= {key1, key0};
         sync2_q <= sync1_q;
         level_q <= level_d;
         press_q <= press_d;
         dbCnt_q <= dbCnt_d;
      end
   end

   assign tick    = (state_q == ST_RUN) && (presc_q == PRESC_LAST);
   assign digitOk = (digit_sw <= 4'd9);
   assign decTime = bcdDecrement(time_q);

   // Next-state logic. Priority: clear, then door, then key1, then the
   // one-second tick, then key0. The prescaler advances on every RUN cycle
   // and holds its value in every other state.
   always_comb begin
      state_d = state_q;
      time_d  = time_q;
      presc_d = presc_q;
      if (state_q == ST_RUN) begin
         presc_d = tick ? '0 : presc_q + PW'(1);
      end
      if (clear) begin
         state_d = ST_IDLE;
         time_d  = 16'h0000;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (press_q[1]) begin
                  if ((time_q != 16'h0000) && !door_open) begin
                     state_d = ST_RUN;
                     presc_d = '0;
                  end
               end else if (press_q[0] && digitOk) begin
                  time_d = {time_q[11:0], digit_sw};
               end
            end
            ST_RUN: begin
               if (door_open || press_q[1]) begin
                  state_d = ST_PAUSE;
               end else if (tick) begin
                  time_d = decTime;
                  if (decTime == 16'h0000) begin
                     state_d = ST_DONE;
                  end
               end
            end
            ST_PAUSE: begin
               if (press_q[1] && !door_open) begin
                  state_d = ST_RUN;
               end
            end
            ST_DONE: begin
               if (press_q[1]) begin
                  state_d = ST_IDLE;
               end else if (press_q[0]) begin
                  state_d = ST_IDLE;
                  time_d  = digitOk ? {12'h000, digit_sw} : 16'h0000;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State, time and status registers; status flags are registered from the
   // next state so they change on the same edge as the state itself.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         time_q    <= 16'h0000;
         presc_q   <= '0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         time_q    <= time_d;
         presc_q   <= presc_d;
         running_q <= (state_d == ST_RUN);
         done_q    <= (state_d == ST_DONE);
      end
   end

   assign time_bcd = time_q;
   assign running  = running_q;
   assign done     = done_q;

   // Binary seconds straight from the BCD digits; 9*600+9*60+9*10+9 fits 13 bits.
   assign remaining = 13'(time_q[15:12]) * 13'd600
                    + 13'(time_q[11:8])  * 13'd60
                    + 13'(time_q[7:4])   * 13'd10
                    + 13'(time_q[3:0]);

endmodule

// File: tb/tb_oven_time_entry.sv
// tb_oven_time_entry
// Self-checking bench for oven_time_entry with a small clock and debounce
// window. A behavioural model built on plain minutes/seconds arithmetic runs
// alongside the design and is compared every cycle; directed scenarios add
// hand-computed literal expectations.
module tb_oven_time_entry;

   localparam int CLK_HZ = 10;
   localparam int DEB    = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        key0 = 1'b1;
   logic        key1 = 1'b1;
   logic [3:0]  digitSw = 4'd0;
   logic        doorOpen = 1'b0;
   logic        clear = 1'b0;
   logic [15:0] timeBcd;
   logic [12:0] remaining;
   logic        running;
   logic        done;

   int total = 0;
   int bad = 0;
   bit checkEn = 1'b0;

   oven_time_entry #(
      .CLK_HZ(CLK_HZ),
      .DEBOUNCE_CYCLES(DEB)
   ) dut (
      .clk(clk),
      .rst(rst),
      .key0(key0),
      .key1(key1),
      .digit_sw(digitSw),
      .door_open(doorOpen),
      .clear(clear),
      .time_bcd(timeBcd),
      .remaining(remaining),
      .running(running),
      .done(done)
   );

   // Free-running clock, 10 time units per period
   always #5 clk = ~clk;

   // Behavioural model state: time kept as integer minutes and seconds
   typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mstate_t;
   mstate_t mState = M_IDLE;
   int mMin = 0;
   int mSec = 0;
   int mPresc = 0;
   bit mS1 [2] = '{1'b1, 1'b1};
   bit mS2 [2] = '{1'b1, 1'b1};
   bit mLvl [2] = '{1'b1, 1'b1};
   bit mPress [2] = '{1'b0, 1'b0};
   int mRun [2] = '{0, 0};

   function automatic logic [15:0] modelBcd();
      return {4'(mMin / 10), 4'(mMin % 10), 4'(mSec / 10), 4'(mSec % 10)};
   endfunction

   // Record one comparison and report it if it does not hold
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive all free inputs at once (used by the random phase)
   task automatic applyStimulus(input logic k0, input logic k1, input logic [3:0] d,
                                input logic door, input logic clr, input logic r);
      key0 = k0;
      key1 = k1;
      digitSw = d;
      doorOpen = door;
      clear = clr;
      rst = r;
   endtask

   // Advance the model by one clock edge: events come from the key pulses
   // registered on the previous edge, then the key path itself moves on.
   always @(posedge clk) begin
      bit ev0, ev1, tick, newPress;
      bit keyNow [2];
      int entry;
      keyNow[0] = key0;
      keyNow[1] = key1;
      if (rst) begin
         mState = M_IDLE;
         mMin = 0;
         mSec = 0;
         mPresc = 0;
         for (int k = 0; k < 2; k++) begin
            mS1[k] = 1'b1;
            mS2[k] = 1'b1;
            mLvl[k] = 1'b1;
            mPress[k] = 1'b0;
            mRun[k] = 0;
         end
      end else begin
         ev0 = mPress[0];
         ev1 = mPress[1];
         tick = (mState == M_RUN) && (mPresc == CLK_HZ - 1);
         if (mState == M_RUN) mPresc = (mPresc + 1) % CLK_HZ;
         if (clear) begin
            mState = M_IDLE;
            mMin = 0;
            mSec = 0;
         end else begin
            case (mState)
               M_IDLE: begin
                  if (ev1) begin
                     if ((mMin + mSec) != 0 && !doorOpen) begin
                        mState = M_RUN;
                        mPresc = 0;
                     end
                  end else if (ev0 && digitSw <= 9) begin
                     entry = ((mMin * 100 + mSec) * 10 + int'(digitSw)) % 10000;
                     mMin = entry / 100;
                     mSec = entry % 100;
                  end
               end
               M_RUN: begin
                  if (doorOpen || ev1) begin
                     mState = M_PAUSE;
                  end else if (tick) begin
                     if (mSec > 0) mSec--;
                     else begin
                        mSec = 59;
                        mMin--;
                     end
                     if (mMin == 0 && mSec == 0) mState = M_DONE;
                  end
               end
               M_PAUSE: begin
                  if (ev1 && !doorOpen) mState = M_RUN;
               end
               M_DONE: begin
                  if (ev1) mState = M_IDLE;
                  else if (ev0) begin
                     mState = M_IDLE;
                     mMin = 0;
                     mSec = (digitSw <= 9) ? int'(digitSw) : 0;
                  end
               end
               default: mState = M_IDLE;
            endcase
         end
         for (int k = 0; k < 2; k++) begin
            newPress = 1'b0;
            if (mS2[k] != mLvl[k]) begin
               mRun[k]++;
               if (mRun[k] == DEB) begin
                  mLvl[k] = mS2[k];
                  mRun[k] = 0;
                  newPress = !mLvl[k];
               end
            end else begin
               mRun[k] = 0;
            end
            mPress[k] = newPress;
            mS2[k] = mS1[k];
            mS1[k] = keyNow[k];
         end
      end
   end

   // Every-cycle comparison of all outputs against the model
   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("model time_bcd", 32'(timeBcd), 32'(modelBcd()));
         checkOutput("model remaining", 32'(remaining), 32'(mMin * 60 + mSec));
         checkOutput("model running", 32'(running), 32'(mState == M_RUN));
         checkOutput("model done", 32'(done), 32'(mState == M_DONE));
      end
   end

   // Hold a key low for a number of cycles, release it and let it settle
   task automatic pressKey(input int k, input int hold);
      if (k == 0) key0 = 1'b0; else key1 = 1'b0;
      repeat (hold) @(negedge clk);
      if (k == 0) key0 = 1'b1; else key1 = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic enterDigit(input logic [3:0] d);
      digitSw = d;
      pressKey(0, 8);
   endtask

   task automatic clearPulse();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      @(negedge clk);
   endtask

   // Bounded wait for the running flag to reach a level
   task automatic waitRunning(input logic v, input string name);
      int n = 0;
      while (running !== v && n < 60) begin
         @(negedge clk);
         n++;
      end
      checkOutput(name, 32'(running), 32'(v));
   endtask

   int holdK0 = 0;
   int holdK1 = 0;
   int holdDoor = 0;
   logic rk0 = 1'b1;
   logic rk1 = 1'b1;
   logic rDoor = 1'b0;
   logic [3:0] rDigit = 4'd0;

   // Directed scenarios followed by a randomized run
   initial begin
      int n;
      @(negedge clk);
      checkEn = 1'b1;
      @(negedge clk);
      checkOutput("reset time", 32'(timeBcd), 32'h0);
      checkOutput("reset remaining", 32'(remaining), 32'd0);
      checkOutput("reset running", 32'(running), 32'd0);
      checkOutput("reset done", 32'(done), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Digit entry and rejection of a non-BCD switch value
      enterDigit(4'd1);
      enterDigit(4'd2);
      enterDigit(4'd3);
      checkOutput("entry 0123", 32'(timeBcd), 32'h0123);
      checkOutput("entry remaining", 32'(remaining), 32'd83);
      enterDigit(4'd12);
      checkOutput("entry reject 12", 32'(timeBcd), 32'h0123);

      // Minute borrow with key0 bouncing throughout
      clearPulse();
      enterDigit(4'd1);
      enterDigit(4'd0);
      enterDigit(4'd0);
      checkOutput("load 0100", 32'(timeBcd), 32'h0100);
      fork pressKey(1, 8); join_none
      waitRunning(1'b1, "start 0100");
      for (int i = 0; i < 10; i++) begin
         key0 = ((i % 4) < 2) ? 1'b0 : 1'b1;
         @(negedge clk);
      end
      key0 = 1'b1;
      checkOutput("borrow 0059", 32'(timeBcd), 32'h0059);
      checkOutput("borrow remaining", 32'(remaining), 32'd59);
      repeat (10) @(negedge clk);

      // Completion to DONE and acknowledge
      clearPulse();
      enterDigit(4'd2);
      fork pressKey(1, 8); join_none
      waitRunning(1'b1, "start 0002");
      repeat (10) @(negedge clk);
      checkOutput("count 0001", 32'(timeBcd), 32'h0001);
      repeat (10) @(negedge clk);
      checkOutput("count 0000", 32'(timeBcd), 32'h0000);
      checkOutput("done set", 32'(done), 32'd1);
      checkOutput("done stops run", 32'(running), 32'd0);
      repeat (6) @(negedge clk);
      pressKey(1, 8);
      checkOutput("ack clears done", 32'(done), 32'd0);

      // Door pause and resume from the held prescaler value
      clearPulse();
      enterDigit(4'd9);
      enterDigit(4'd0);
      fork pressKey(1, 8); join_none
      waitRunning(1'b1, "start 0090");
      n = 0;
      while (mPresc != 4 && n < 20) begin
         @(negedge clk);
         n++;
      end
      doorOpen = 1'b1;
      repeat (50) @(negedge clk);
      checkOutput("door hold time", 32'(timeBcd), 32'h0090);
      checkOutput("door paused", 32'(running), 32'd0);
      doorOpen = 1'b0;
      fork pressKey(1, 8); join_none
      waitRunning(1'b1, "resume 0090");
      repeat (4) @(negedge clk);
      checkOutput("resume before tick", 32'(timeBcd), 32'h0090);
      @(negedge clk);
      checkOutput("resume tick 0089", 32'(timeBcd), 32'h0089);

      // key1 press landing on the tick cycle pauses without decrementing
      repeat (13) @(negedge clk);
      fork pressKey(1, 8); join_none
      waitRunning(1'b0, "pause on tick");
      checkOutput("tick dropped 0088", 32'(timeBcd), 32'h0088);
      repeat (12) @(negedge clk);

      // clear during RUN, then start refused with zero time
      clearPulse();
      enterDigit(4'd4);
      enterDigit(4'd0);
      fork pressKey(1, 8); join_none
      waitRunning(1'b1, "start 0040");
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      checkOutput("clear time", 32'(timeBcd), 32'h0);
      checkOutput("clear stops run", 32'(running), 32'd0);
      repeat (12) @(negedge clk);
      pressKey(1, 8);
      checkOutput("zero start refused", 32'(running), 32'd0);

      // Reset during RUN, then a key held through reset
      enterDigit(4'd5);
      fork pressKey(1, 8); join_none
      waitRunning(1'b1, "start 0005");
      rst = 1'b1;
      key0 = 1'b0;
      digitSw = 4'd7;
      @(negedge clk);
      checkOutput("rst time", 32'(timeBcd), 32'h0);
      checkOutput("rst remaining", 32'(remaining), 32'd0);
      checkOutput("rst running", 32'(running), 32'd0);
      checkOutput("rst done", 32'(done), 32'd0);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      checkOutput("held key window", 32'(timeBcd), 32'h0);
      @(negedge clk);
      checkOutput("held key accepted", 32'(timeBcd), 32'h0007);
      key0 = 1'b1;
      repeat (10) @(negedge clk);

      // Randomized run: key levels held for random spans so both clean
      // presses and bounces occur, with occasional door, clear and reset.
      for (int c = 0; c < 6000; c++) begin
         if (holdK0 == 0) begin
            rk0 = ~rk0;
            holdK0 = rk0 ? int'($urandom_range(2, 30)) : int'($urandom_range(1, 10));
         end
         if (holdK1 == 0) begin
            rk1 = ~rk1;
            holdK1 = rk1 ? int'($urandom_range(2, 40)) : int'($urandom_range(1, 10));
         end
         if (holdDoor == 0) begin
            rDoor = ($urandom_range(0, 9) == 0);
            holdDoor = int'($urandom_range(1, 25));
         end
         if ($urandom_range(0, 7) == 0) rDigit = 4'($urandom_range(0, 11));
         applyStimulus(rk0, rk1, rDigit, rDoor,
                       ($urandom_range(0, 199) == 0), ($urandom_range(0, 1999) == 0));
         holdK0--;
         holdK1--;
         holdDoor--;
         @(negedge clk);
      end
      applyStimulus(1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
      repeat (4) @(negedge clk);

      checkEn = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
